obi_hart_arbiter: RTL and testbench
===================================

Name: obi_hart_arbiter

Overview:
- Shares one OBI master port among NHARTS OBI requesters, for example the per-hart data ports of the CPU system.
- Applies round-robin arbitration to address-phase handshakes.
- Keeps an in-order ID FIFO so that each response is routed to the hart that issued the request.
- Sits between the CPU system and a single bus/memory slave port. It adds no latency on the address or response path.

Parameters:
- NHARTS, 3, number of requester ports (1..8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..8); this is the ID FIFO depth.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- hart_req_i  in  [NHARTS-1:0] obi_req_t  per-hart request (req, we, be, addr, wdata).
- hart_resp_o  out  [NHARTS-1:0] obi_resp_t  per-hart response (gnt, rvalid, rdata).
- bus_req_o  out  obi_req_t  shared master request.
- bus_resp_i  in  obi_resp_t  shared master response.
- outstanding_o  out  CNT_W  current ID FIFO occupancy.
- rvalid_err_o  out  1  sticky flag; set on a bus rvalid received while the FIFO is empty.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, FIFO empty, outstanding_o=0, rvalid_err_o=0.
  - All bus_req_o fields 0; all hart_resp_o gnt/rvalid 0.
- Selection (combinational):
  - sel = first index i with hart_req_i[i].req=1, scanning rr_ptr, rr_ptr+1, ... modulo NHARTS.
  - any_req = OR of all hart req bits.
- Address phase:
  - bus_req_o.req = any_req & !full.
  - addr/we/be/wdata = hart_req_i[sel] fields when bus_req_o.req=1, else 0.
  - hart_resp_o[sel].gnt = bus_resp_i.gnt & bus_req_o.req; gnt=0 for every other hart.
  - Zero-cycle passthrough: a grant in cycle N is visible to the hart in cycle N.
- Handshake (bus_req_o.req & bus_resp_i.gnt) at a clock edge:
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NHARTS.
  - rr_ptr is unchanged in cycles without a handshake, so a hart waiting for gnt keeps priority.
- Full:
  - full = (count == MAX_OUTSTANDING).
  - When full, bus_req_o.req=0 even if a response pops in the same cycle; no bypass.
  - A new grant is possible from the following cycle.
- Response phase:
  - When bus_resp_i.rvalid=1 and the FIFO is non-empty: hart_resp_o[head].rvalid=1 and the FIFO pops.
  - rdata is broadcast to all harts; rvalid goes only to the head ID.
  - When bus_resp_i.rvalid=1 and the FIFO is empty: no hart sees rvalid and rvalid_err_o <= 1. It stays set until reset.
- Simultaneous push and pop (not full):
  - Both happen and count is unchanged.
  - The pushed ID goes behind the popped one, so order is preserved.
  - A response in the same cycle as a grant belongs to the older transaction.
- Ordering assumptions:
  - The slave answers strictly in order.
  - rvalid is never asserted in the same cycle as the gnt of the same transaction; earliest rvalid is cycle N+1.
- FIFO implementation:
  - Circular buffer, wr/rd pointers wrap modulo MAX_OUTSTANDING.
  - Width of each ID is $clog2(NHARTS) (minimum 1).
  - outstanding_o = count register.
- Hart-side rules:
  - A hart must hold req and its fields stable until gnt; the arbiter does not check this.
  - A hart that drops req before gnt simply loses its slot.
- Reset mid-operation: outstanding transactions are forgotten; later stray rvalids set rvalid_err_o.

Test Plan:
- Single hart 1, read to 0x0000_1000, slave gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF:
  - gnt seen only by hart 1, rvalid seen only by hart 1 with 0xDEADBEEF.
  - outstanding_o goes 0->1->0; rr_ptr=2 afterwards.
- Harts 0, 1, 2 request continuously, slave always gnt, rvalid one cycle later:
  - Grant order is 0,1,2,0,1,2.
  - rvalids arrive at 0,1,2,... in the same order.
  - outstanding_o never exceeds 1.
- MAX_OUTSTANDING=2, slave holds rvalid low for 5 cycles, all harts requesting:
  - Exactly 2 grants (harts 0,1), then bus_req_o.req=0 and outstanding_o=2.
  - First rvalid goes to hart 0; the next cycle grants hart 2.
- Pop and push in the same cycle with count=1:
  - Count stays 1, the response goes to the older ID, and the new ID is routed on the next rvalid.
- bus rvalid with the FIFO empty:
  - No hart rvalid and rvalid_err_o=1.
  - It stays 1 through further traffic until rst_ni pulses low.
- Assert rst_ni low with 2 outstanding:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, hart 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/obi_hart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : obi_hart_arbiter
//  Purpose  : Shares one OBI master port among NHARTS OBI requesters.
//             Address-phase handshakes are arbitrated round-robin. An
//             in-order ID FIFO routes each response back to the hart that
//             issued the request. Grants and responses pass through
//             combinationally, so the arbiter adds no cycles of latency.
//  Ports    : clk_i          - clock
//             rst_ni         - asynchronous active-low reset
//             hart_req_i     - per-hart request (req, we, be, addr, wdata)
//             hart_resp_o    - per-hart response (gnt, rvalid, rdata)
//             bus_req_o      - shared master request
//             bus_resp_i     - shared master response
//             outstanding_o  - current ID FIFO occupancy
//             rvalid_err_o   - sticky flag: bus rvalid seen with FIFO empty
//  Revision : 1.0 - initial release
// ============================================================================

typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
} obi_req_t;

typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
} obi_resp_t;

module obi_hart_arbiter #(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  obi_req_t  [NHARTS-1:0]   hart_req_i,
    output obi_resp_t [NHARTS-1:0]   hart_resp_o,
    output obi_req_t                 bus_req_o,
    input  obi_resp_t                bus_resp_i,
    output logic      [CNT_W-1:0]    outstanding_o,
    output logic                     rvalid_err_o
);

    localparam int c_id_w  = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [c_id_w-1:0]  c_last_id  = c_id_w'(NHARTS - 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]   c_max_cnt  = CNT_W'(MAX_OUTSTANDING);

    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_id_w-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic [c_id_w-1:0]  w_sel;
    logic [c_id_w-1:0]  w_idx;
    logic               w_any_req;
    logic               w_full;
    logic               w_bus_req;
    logic               w_push;
    logic               w_pop;
    logic               w_stray;
    logic [c_id_w-1:0]  w_head;

    // Round-robin scan: first requesting hart at or after r_rr_ptr wins.
    always_comb begin : p_select
        w_sel     = r_rr_ptr;
        w_idx     = '0;
        w_any_req = 1'b0;
        for (int k = 0; k < NHARTS; k++) begin
            w_idx = c_id_w'((int'(r_rr_ptr) + k) % NHARTS);
            if (!w_any_req && hart_req_i[w_idx].req) begin
                w_sel     = w_idx;
                w_any_req = 1'b1;
            end
        end
    end

    // No bypass when full: a pop in the same cycle does not free a slot
    // until the next cycle. The request is also masked while reset is held
    // so the bus sees idle outputs as soon as reset asserts.
    assign w_full    = (r_count == c_max_cnt);
    assign w_bus_req = w_any_req & ~w_full & rst_ni;
    assign w_push    = w_bus_req & bus_resp_i.gnt;
    assign w_pop     = bus_resp_i.rvalid & (r_count != '0);
    assign w_stray   = bus_resp_i.rvalid & (r_count == '0);
    assign w_head    = r_fifo[r_rd_ptr];

    always_comb begin : p_bus_mux
        bus_req_o = '0;
        if (w_bus_req) begin
            bus_req_o     = hart_req_i[w_sel];
            bus_req_o.req = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_resp
        assign hart_resp_o[gi].gnt    = w_push & (w_sel == c_id_w'(gi));
        assign hart_resp_o[gi].rvalid = w_pop & (w_head == c_id_w'(gi));
        assign hart_resp_o[gi].rdata  = bus_resp_i.rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_fifo   <= '{default: '0};
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                r_rr_ptr         <= (w_sel == c_last_id) ? '0 : w_sel + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outstanding_o = r_count;
    assign rvalid_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_hart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obi_hart_arbiter
//  Purpose  : Self-checking bench for obi_hart_arbiter (3 harts, depth 2).
//             Directed vector table, hand-written corner sequences and a
//             randomized phase checked against a queue-based reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obi_hart_arbiter;

    localparam int N   = 3;
    localparam int MAX = 2;

    logic                clk;
    logic                rst_n;
    obi_req_t  [N-1:0]   hart_req;
    obi_resp_t [N-1:0]   hart_resp;
    obi_req_t            bus_req;
    obi_resp_t           bus_resp;
    logic [1:0]          outstanding;
    logic                rvalid_err;

    obi_hart_arbiter #(
        .NHARTS          (N),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .hart_req_i    (hart_req),
        .hart_resp_o   (hart_resp),
        .bus_req_o     (bus_req),
        .bus_resp_i    (bus_resp),
        .outstanding_o (outstanding),
        .rvalid_err_o  (rvalid_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] h_addr  [N];
    logic [31:0] h_wdata [N];
    logic [3:0]  h_be    [N];
    logic        h_we    [N];

    // Reference model: queue of outstanding hart IDs plus round-robin pointer.
    int mq[$];
    int m_rr;
    bit m_err;

    typedef struct {
        string       nm;
        logic [2:0]  req;
        bit          g;
        bit          rv;
        logic [31:0] rd;
        bit          e_busreq;
        int          e_sel;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        int          e_out;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: applies inputs, checks outputs, advances one cycle.
    task automatic drive(input string nm, input logic [2:0] req, input bit g, input bit rv,
                         input logic [31:0] rd, input bit e_busreq, input int e_sel,
                         input logic [2:0] e_gnt, input logic [2:0] e_rv, input int e_out,
                         input bit e_err);
        logic [2:0] a_gnt;
        logic [2:0] a_rv;
        for (int i = 0; i < N; i++) begin
            hart_req[i].req   = req[i];
            hart_req[i].we    = h_we[i];
            hart_req[i].be    = h_be[i];
            hart_req[i].addr  = h_addr[i];
            hart_req[i].wdata = h_wdata[i];
        end
        bus_resp.gnt    = g;
        bus_resp.rvalid = rv;
        bus_resp.rdata  = rd;
        #1;
        for (int i = 0; i < N; i++) begin
            a_gnt[i] = hart_resp[i].gnt;
            a_rv[i]  = hart_resp[i].rvalid;
            chk({nm, " rdata"}, 64'(hart_resp[i].rdata), 64'(rd));
        end
        chk({nm, " bus_req"}, 64'(bus_req.req), 64'(e_busreq));
        if (e_busreq && e_sel >= 0) begin
            chk({nm, " addr"},  64'(bus_req.addr),  64'(h_addr[e_sel]));
            chk({nm, " wdata"}, 64'(bus_req.wdata), 64'(h_wdata[e_sel]));
            chk({nm, " we_be"}, 64'({bus_req.we, bus_req.be}), 64'({h_we[e_sel], h_be[e_sel]}));
        end else begin
            chk({nm, " idle_fields"}, 64'({bus_req.addr, bus_req.wdata[15:0], bus_req.we, bus_req.be}), 64'(0));
        end
        chk({nm, " gnt"},         64'(a_gnt),       64'(e_gnt));
        chk({nm, " rvalid"},      64'(a_rv),        64'(e_rv));
        chk({nm, " outstanding"}, 64'(outstanding), 64'(e_out));
        chk({nm, " rvalid_err"},  64'(rvalid_err),  64'(e_err));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) hart_req[i] = '0;
        bus_resp = '0;
        #1;
        chk("reset bus_req", 64'(bus_req), 64'(0));
        chk("reset outstanding", 64'(outstanding), 64'(0));
        chk("reset rvalid_err", 64'(rvalid_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_rr  = 0;
        m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_eval(input logic [2:0] req, input bit g, input bit rv,
                              output bit e_busreq, output int e_sel, output logic [2:0] e_gnt,
                              output logic [2:0] e_rv, output int e_out, output bit e_err);
        int first;
        first = -1;
        for (int k = 0; k < N; k++) begin
            int h;
            h = (m_rr + k) % N;
            if (first < 0 && req[h]) first = h;
        end
        e_busreq = (first >= 0) && (mq.size() < MAX);
        e_sel    = e_busreq ? first : -1;
        e_gnt    = '0;
        if (e_busreq && g) e_gnt[first] = 1'b1;
        e_rv = '0;
        if (rv && mq.size() > 0) e_rv[mq[0]] = 1'b1;
        e_out = mq.size();
        e_err = m_err;
    endtask

    task automatic model_commit(input bit hs, input int sel, input bit rv);
        if (rv) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1'b1;
        end
        if (hs) begin
            mq.push_back(sel);
            m_rr = (sel + 1) % N;
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          e_busreq;
        int          e_sel;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        int          e_out;
        bit          e_err;
        logic [2:0]  r_req;
        bit          r_g;
        bit          r_rv;
        logic [31:0] r_rd;

        for (int i = 0; i < N; i++) begin
            h_addr[i]  = 32'h0000_1000 * i;
            h_wdata[i] = 32'hA000_0000 | i;
            h_be[i]    = 4'hF >> i;
            h_we[i]    = i[0];
        end
        rst_n    = 1'b1;
        hart_req = '0;
        bus_resp = '0;
        @(negedge clk);
        do_reset();

        // Round-robin with continuous requests, then single hart 1 read.
        vecs.push_back('{"rr0", 3'b111, 1, 0, 32'h0,        1,  0, 3'b001, 3'b000, 0, 0});
        vecs.push_back('{"rr1", 3'b111, 1, 1, 32'h11,       1,  1, 3'b010, 3'b001, 1, 0});
        vecs.push_back('{"rr2", 3'b111, 1, 1, 32'h22,       1,  2, 3'b100, 3'b010, 1, 0});
        vecs.push_back('{"rr3", 3'b111, 1, 1, 32'h33,       1,  0, 3'b001, 3'b100, 1, 0});
        vecs.push_back('{"rr4", 3'b111, 1, 1, 32'h44,       1,  1, 3'b010, 3'b001, 1, 0});
        vecs.push_back('{"rr5", 3'b111, 1, 1, 32'h55,       1,  2, 3'b100, 3'b010, 1, 0});
        vecs.push_back('{"rr6", 3'b000, 1, 1, 32'h66,       0, -1, 3'b000, 3'b100, 1, 0});
        vecs.push_back('{"rr7", 3'b000, 0, 0, 32'h0,        0, -1, 3'b000, 3'b000, 0, 0});
        vecs.push_back('{"h1a", 3'b010, 1, 0, 32'h0,        1,  1, 3'b010, 3'b000, 0, 0});
        vecs.push_back('{"h1b", 3'b000, 0, 1, 32'hDEADBEEF, 0, -1, 3'b000, 3'b010, 1, 0});
        vecs.push_back('{"h1c", 3'b000, 0, 0, 32'h0,        0, -1, 3'b000, 3'b000, 0, 0});
        vecs.push_back('{"hold", 3'b111, 0, 0, 32'h0,       1,  2, 3'b000, 3'b000, 0, 0});
        vecs.push_back('{"rr_p2", 3'b111, 1, 0, 32'h0,      1,  2, 3'b100, 3'b000, 0, 0});
        vecs.push_back('{"rr_p2r", 3'b000, 0, 1, 32'h77,    0, -1, 3'b000, 3'b100, 1, 0});
        vecs.push_back('{"idle", 3'b000, 0, 0, 32'h0,       0, -1, 3'b000, 3'b000, 0, 0});
        foreach (vecs[v]) begin
            drive(vecs[v].nm, vecs[v].req, vecs[v].g, vecs[v].rv, vecs[v].rd, vecs[v].e_busreq,
                  vecs[v].e_sel, vecs[v].e_gnt, vecs[v].e_rv, vecs[v].e_out, vecs[v].e_err);
        end

        // Full FIFO: two grants, stall, no bypass on pop, then push+pop with count 1.
        do_reset();
        drive("full0", 3'b111, 1, 0, 32'h0,  1,  0, 3'b001, 3'b000, 0, 0);
        drive("full1", 3'b111, 1, 0, 32'h0,  1,  1, 3'b010, 3'b000, 1, 0);
        drive("full2", 3'b111, 1, 0, 32'h0,  0, -1, 3'b000, 3'b000, 2, 0);
        drive("full3", 3'b111, 1, 0, 32'h0,  0, -1, 3'b000, 3'b000, 2, 0);
        drive("full4", 3'b111, 1, 0, 32'h0,  0, -1, 3'b000, 3'b000, 2, 0);
        drive("full5", 3'b111, 1, 1, 32'hA0, 0, -1, 3'b000, 3'b001, 2, 0);
        drive("full6", 3'b111, 1, 0, 32'h0,  1,  2, 3'b100, 3'b000, 1, 0);
        drive("full7", 3'b111, 1, 1, 32'hA1, 0, -1, 3'b000, 3'b010, 2, 0);
        drive("pp8",   3'b111, 1, 1, 32'hA2, 1,  0, 3'b001, 3'b100, 1, 0);
        drive("pp9",   3'b000, 0, 1, 32'hA3, 0, -1, 3'b000, 3'b001, 1, 0);
        // Stray rvalid with the FIFO empty; flag is sticky through traffic.
        drive("stray", 3'b000, 0, 1, 32'hA4, 0, -1, 3'b000, 3'b000, 0, 0);
        drive("err1",  3'b000, 0, 0, 32'h0,  0, -1, 3'b000, 3'b000, 0, 1);
        drive("err2",  3'b010, 1, 0, 32'h0,  1,  1, 3'b010, 3'b000, 0, 1);
        drive("err3",  3'b000, 0, 1, 32'hA5, 0, -1, 3'b000, 3'b010, 1, 1);
        // Two outstanding, then asynchronous reset mid-cycle.
        drive("pre0",  3'b111, 1, 0, 32'h0,  1,  2, 3'b100, 3'b000, 0, 1);
        drive("pre1",  3'b111, 1, 0, 32'h0,  1,  0, 3'b001, 3'b000, 1, 1);
        bus_resp.gnt = 1'b1;
        for (int i = 0; i < N; i++) hart_req[i].req = 1'b1;
        #2;
        chk("pre_rst outstanding", 64'(outstanding), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("async_rst bus_req", 64'(bus_req), 64'(0));
        chk("async_rst gnt", 64'({hart_resp[2].gnt, hart_resp[1].gnt, hart_resp[0].gnt}), 64'(0));
        chk("async_rst outstanding", 64'(outstanding), 64'(0));
        chk("async_rst rvalid_err", 64'(rvalid_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive("post0", 3'b000, 0, 1, 32'hB0, 0, -1, 3'b000, 3'b000, 0, 0);
        drive("post1", 3'b111, 1, 0, 32'h0,  1,  0, 3'b001, 3'b000, 0, 1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                h_addr[i]  = $urandom;
                h_wdata[i] = $urandom;
                h_be[i]    = 4'($urandom);
                h_we[i]    = 1'($urandom);
            end
            r_req = 3'($urandom_range(0, 7));
            r_g   = 1'($urandom);
            r_rd  = $urandom;
            if (mq.size() > 0) r_rv = ($urandom_range(0, 99) < 55);
            else               r_rv = ($urandom_range(0, 99) < 3);
            model_eval(r_req, r_g, r_rv, e_busreq, e_sel, e_gnt, e_rv, e_out, e_err);
            drive("rand", r_req, r_g, r_rv, r_rd, e_busreq, e_sel, e_gnt, e_rv, e_out, e_err);
            model_commit(e_busreq && r_g, e_sel, r_rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
